// File: rtl/target_spawner_if.sv
// Handshake bundle between the game controller, the random generator,
// the tracker and the target spawner.
interface target_spawner_if;
  logic       i_start;
  logic [3:0] i_rand;
  logic       i_hit;
  logic       o_target_valid;
  logic [3:0] o_cell;
  logic [7:0] o_score;
  logic [7:0] o_miss;
  logic [7:0] o_round;
  logic       o_done;

  // Driver side: game controller / random generator / tracker.
  modport master (
    output i_start, i_rand, i_hit,
    input  o_target_valid, o_cell, o_score, o_miss, o_round, o_done
  );

  // Spawner side.
  modport slave (
    input  i_start, i_rand, i_hit,
    output o_target_valid, o_cell, o_score, o_miss, o_round, o_done
  );
endinterface

// File: rtl/target_spawner.sv
// Target spawner for the object-tracking game. A start rising edge runs
// MAX_ROUNDS rounds; each round shows one cell of the 4x4 grid until the
// tracker hits it or LIFETIME cycles pass, followed by a GAP_CYCLES pause.
// Hits and timeouts are counted (saturating) for the score display.
module target_spawner #(
  parameter int LIFETIME   = 1000,
  parameter int GAP_CYCLES = 100,
  parameter int MAX_ROUNDS = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  target_spawner_if.slave bus
);

  // Timer only needs to reach LIFETIME-1, gap counter only GAP_CYCLES-1.
  localparam int TMR_W = (LIFETIME   > 2) ? $clog2(LIFETIME)   : 1;
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(LIFETIME - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       ROUND_LAST = 8'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPAWN  = 3'd1,
    S_ACTIVE = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state;
  logic             start_d;
  logic [3:0]       last_cell;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;

  logic             target_valid_q;
  logic [3:0]       cell_q;
  logic [7:0]       score_q;
  logic [7:0]       miss_q;
  logic [7:0]       round_q;
  logic             done_q;

  logic             start_rise;
  logic [3:0]       spawn_cell;

  // Counters stick at full scale instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Never show the same cell twice in a row within a game; bumping by one
  // (with 4-bit wrap) keeps the choice cheap and still unpredictable.
  function automatic logic [3:0] pick_cell(input logic [3:0] r,
                                           input logic [3:0] last,
                                           input logic       first_round);
    return (!first_round && (r == last)) ? r + 4'd1 : r;
  endfunction

  // Start edge detect and the cell that a SPAWN cycle would register.
  always_comb begin
    start_rise = bus.i_start & ~start_d;
    spawn_cell = pick_cell(bus.i_rand, last_cell, (round_q == 8'd0));
  end

  // Game sequencer: all state and all outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      start_d        <= 1'b0;
      last_cell      <= 4'd0;
      timer          <= '0;
      gap_cnt        <= '0;
      target_valid_q <= 1'b0;
      cell_q         <= 4'd0;
      score_q        <= 8'd0;
      miss_q         <= 8'd0;
      round_q        <= 8'd0;
      done_q         <= 1'b0;
    end else begin
      start_d <= bus.i_start;
      case (state)
        S_IDLE: begin
          if (start_rise) begin
            state <= S_SPAWN;
          end
        end

        S_SPAWN: begin
          cell_q         <= spawn_cell;
          last_cell      <= spawn_cell;
          timer          <= '0;
          target_valid_q <= 1'b1;
          state          <= S_ACTIVE;
        end

        S_ACTIVE: begin
          timer <= timer + TMR_W'(1);
          // A hit on the last live cycle still counts as a hit.
          if (bus.i_hit || (timer == TMR_LAST)) begin
            if (bus.i_hit) begin
              score_q <= sat_inc8(score_q);
            end else begin
              miss_q <= sat_inc8(miss_q);
            end
            target_valid_q <= 1'b0;
            round_q        <= sat_inc8(round_q);
            gap_cnt        <= '0;
            state          <= S_GAP;
          end
        end

        S_GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (gap_cnt == GAP_LAST) begin
            if (round_q == ROUND_LAST) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_SPAWN;
            end
          end
        end

        S_DONE: begin
          // Scores stay visible until the next game actually begins.
          if (start_rise) begin
            score_q <= 8'd0;
            miss_q  <= 8'd0;
            round_q <= 8'd0;
            done_q  <= 1'b0;
            state   <= S_SPAWN;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_target_valid = target_valid_q;
  assign bus.o_cell         = cell_q;
  assign bus.o_score        = score_q;
  assign bus.o_miss         = miss_q;
  assign bus.o_round        = round_q;
  assign bus.o_done         = done_q;

endmodule

// File: tb/tb_target_spawner.sv
// Bench for target_spawner with LIFETIME=8, GAP_CYCLES=4, MAX_ROUNDS=3.
// Expected cells come from a small reference model and travel through a
// queue from the moment i_rand is driven until the target appears.
module tb_target_spawner;
  localparam int LT = 8;
  localparam int GP = 4;
  localparam int MR = 3;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  target_spawner_if bus();

  target_spawner #(
    .LIFETIME  (LT),
    .GAP_CYCLES(GP),
    .MAX_ROUNDS(MR)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_q[$];
  int         m_round;
  logic [3:0] m_last = 4'd0;

  logic [3:0] obs_cell[MR];
  int         obs_len[MR];
  int         obs_low[MR];
  int         wait_fails;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference choice of cell for a given random value; pushes the result.
  function automatic void model_spawn(input logic [3:0] r);
    logic [3:0] c;
    c = r;
    if (m_round > 0 && r == m_last) c = r + 4'd1;
    m_last = c;
    m_round++;
    exp_q.push_back(c);
  endfunction

  function automatic logic [3:0] pop_exp();
    if (exp_q.size() == 0) return 4'hx;
    return exp_q.pop_front();
  endfunction

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!bus.o_target_valid && n < 60) begin
      tick();
      n++;
    end
    ok = bus.o_target_valid;
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (!bus.o_done && n < 300) begin
      tick();
      n++;
    end
    ok = bus.o_done;
  endtask

  // Called with valid just seen high; counts high samples, pulses i_hit
  // after the hit_at-th one (0 = never).
  task automatic run_target(input int hit_at, output int len);
    len = 0;
    bus.i_hit = 1'b0;
    while (bus.o_target_valid && len < 100) begin
      len++;
      if (len == hit_at) bus.i_hit = 1'b1;
      tick();
      bus.i_hit = 1'b0;
    end
  endtask

  // Counts low samples until the next target or the end of the game.
  task automatic measure_gap(input bit gap_hit, output int low);
    low = 0;
    while (!bus.o_target_valid && !bus.o_done && low < 100) begin
      bus.i_hit = gap_hit;
      low++;
      tick();
    end
    bus.i_hit = 1'b0;
  endtask

  // Plays one game from IDLE/DONE, with a fresh i_rand before every spawn.
  task automatic run_game(input logic [3:0] rs[MR], input int hit_at, input bit gap_hit);
    bit ok;
    wait_fails = 0;
    exp_q.delete();
    for (int r = 0; r < MR; r++) begin
      obs_cell[r] = 4'hx;
      obs_len[r]  = -1;
      obs_low[r]  = -1;
    end
    bus.i_start = 1'b0;
    tick();
    m_round = 0;
    bus.i_rand = rs[0];
    model_spawn(rs[0]);
    bus.i_start = 1'b1;
    for (int r = 0; r < MR; r++) begin
      wait_valid(ok);
      if (!ok) begin
        wait_fails++;
        return;
      end
      obs_cell[r] = bus.o_cell;
      run_target(hit_at, obs_len[r]);
      if (r + 1 < MR) begin
        bus.i_rand = rs[r+1];
        model_spawn(rs[r+1]);
      end
      measure_gap(gap_hit, obs_low[r]);
    end
  endtask

  task automatic test_reset();
    n_checks++; if (bus.o_target_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.o_target_valid); else n_pass++;
    n_checks++; if (bus.o_cell !== 4'd0) $display("FAIL reset_cell: got %0d want 0", bus.o_cell); else n_pass++;
    n_checks++; if (bus.o_score !== 8'd0) $display("FAIL reset_score: got %0d want 0", bus.o_score); else n_pass++;
    n_checks++; if (bus.o_miss !== 8'd0) $display("FAIL reset_miss: got %0d want 0", bus.o_miss); else n_pass++;
    n_checks++; if (bus.o_round !== 8'd0) $display("FAIL reset_round: got %0d want 0", bus.o_round); else n_pass++;
    n_checks++; if (bus.o_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", bus.o_done); else n_pass++;
    i_rst_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus.o_target_valid !== 1'b0) $display("FAIL idle_valid: got %0b want 0", bus.o_target_valid); else n_pass++;
  endtask

  task automatic test_first_spawn();
    bit ok;
    int cnt;
    logic [3:0] e;
    exp_q.delete();
    m_round = 0;
    bus.i_rand = 4'd5;
    model_spawn(4'd5);
    bus.i_start = 1'b1;
    tick();
    n_checks++; if (bus.o_target_valid !== 1'b0) $display("FAIL latency_early: valid got %0b want 0", bus.o_target_valid); else n_pass++;
    tick();
    n_checks++; if (bus.o_target_valid !== 1'b1) $display("FAIL latency_valid: got %0b want 1", bus.o_target_valid); else n_pass++;
    e = pop_exp();
    n_checks++; if (bus.o_cell !== e) $display("FAIL first_cell: got %0d want %0d", bus.o_cell, e); else n_pass++;
    wait_done(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL first_game_done: got %0b want 1", ok); else n_pass++;
    cnt = 0;
    repeat (20) begin
      tick();
      if (bus.o_target_valid) cnt++;
    end
    n_checks++; if (cnt !== 0) $display("FAIL held_start_retrigger: valid samples %0d want 0", cnt); else n_pass++;
    n_checks++; if (bus.o_round !== 8'd3) $display("FAIL held_start_round: got %0d want 3", bus.o_round); else n_pass++;
  endtask

  task automatic test_no_hits();
    logic [3:0] rs[MR];
    logic [3:0] e;
    rs = '{4'd5, 4'd5, 4'd9};
    run_game(rs, 0, 1'b0);
    n_checks++; if (wait_fails !== 0) $display("FAIL nohit_wait: timeouts %0d want 0", wait_fails); else n_pass++;
    for (int r = 0; r < MR; r++) begin
      e = pop_exp();
      n_checks++; if (obs_cell[r] !== e) $display("FAIL nohit_cell%0d: got %0d want %0d", r, obs_cell[r], e); else n_pass++;
      n_checks++; if (obs_len[r] !== LT) $display("FAIL nohit_len%0d: got %0d want %0d", r, obs_len[r], LT); else n_pass++;
      n_checks++; if (obs_low[r] !== ((r == MR-1) ? GP : GP+1)) $display("FAIL nohit_low%0d: got %0d want %0d", r, obs_low[r], (r == MR-1) ? GP : GP+1); else n_pass++;
    end
    n_checks++; if (bus.o_miss !== 8'd3) $display("FAIL nohit_miss: got %0d want 3", bus.o_miss); else n_pass++;
    n_checks++; if (bus.o_score !== 8'd0) $display("FAIL nohit_score: got %0d want 0", bus.o_score); else n_pass++;
    n_checks++; if (bus.o_round !== 8'd3) $display("FAIL nohit_round: got %0d want 3", bus.o_round); else n_pass++;
    n_checks++; if (bus.o_done !== 1'b1) $display("FAIL nohit_done: got %0b want 1", bus.o_done); else n_pass++;
  endtask

  task automatic test_hits();
    logic [3:0] rs[MR];
    logic [3:0] e;
    rs = '{4'd2, 4'd11, 4'd11};
    run_game(rs, 3, 1'b1);
    n_checks++; if (wait_fails !== 0) $display("FAIL hit_wait: timeouts %0d want 0", wait_fails); else n_pass++;
    for (int r = 0; r < MR; r++) begin
      e = pop_exp();
      n_checks++; if (obs_cell[r] !== e) $display("FAIL hit_cell%0d: got %0d want %0d", r, obs_cell[r], e); else n_pass++;
      n_checks++; if (obs_len[r] !== 3) $display("FAIL hit_len%0d: got %0d want 3", r, obs_len[r]); else n_pass++;
    end
    n_checks++; if (bus.o_score !== 8'd3) $display("FAIL hit_score: got %0d want 3", bus.o_score); else n_pass++;
    n_checks++; if (bus.o_miss !== 8'd0) $display("FAIL hit_miss: got %0d want 0", bus.o_miss); else n_pass++;
    bus.i_hit = 1'b1;
    repeat (3) tick();
    bus.i_hit = 1'b0;
    tick();
    n_checks++; if (bus.o_score !== 8'd3) $display("FAIL done_hit_score: got %0d want 3", bus.o_score); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [3:0] rs[MR];
    logic [3:0] e;
    rs = '{4'd15, 4'd15, 4'd15};
    run_game(rs, 0, 1'b0);
    n_checks++; if (wait_fails !== 0) $display("FAIL wrap15_wait: timeouts %0d want 0", wait_fails); else n_pass++;
    for (int r = 0; r < MR; r++) begin
      e = pop_exp();
      n_checks++; if (obs_cell[r] !== e) $display("FAIL wrap15_cell%0d: got %0d want %0d", r, obs_cell[r], e); else n_pass++;
    end
    rs = '{4'd7, 4'd7, 4'd7};
    run_game(rs, 0, 1'b0);
    n_checks++; if (wait_fails !== 0) $display("FAIL rep7_wait: timeouts %0d want 0", wait_fails); else n_pass++;
    for (int r = 0; r < MR; r++) begin
      e = pop_exp();
      n_checks++; if (obs_cell[r] !== e) $display("FAIL rep7_cell%0d: got %0d want %0d", r, obs_cell[r], e); else n_pass++;
    end
  endtask

  task automatic test_hit_timeout_and_reset();
    logic [3:0] rs[MR];
    logic [3:0] e;
    bit ok;
    rs = '{4'd1, 4'd2, 4'd3};
    run_game(rs, LT, 1'b0);
    n_checks++; if (wait_fails !== 0) $display("FAIL tie_wait: timeouts %0d want 0", wait_fails); else n_pass++;
    n_checks++; if (obs_len[0] !== LT) $display("FAIL tie_len: got %0d want %0d", obs_len[0], LT); else n_pass++;
    n_checks++; if (bus.o_score !== 8'd3) $display("FAIL tie_score: got %0d want 3", bus.o_score); else n_pass++;
    n_checks++; if (bus.o_miss !== 8'd0) $display("FAIL tie_miss: got %0d want 0", bus.o_miss); else n_pass++;
    // New game, then reset while its first target is live.
    bus.i_start = 1'b0;
    tick();
    bus.i_start = 1'b1;
    wait_valid(ok);
    repeat (2) tick();
    n_checks++; if (bus.o_target_valid !== 1'b1) $display("FAIL prereset_valid: got %0b want 1", bus.o_target_valid); else n_pass++;
    i_rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_target_valid !== 1'b0) $display("FAIL midreset_valid: got %0b want 0", bus.o_target_valid); else n_pass++;
    n_checks++; if (bus.o_cell !== 4'd0) $display("FAIL midreset_cell: got %0d want 0", bus.o_cell); else n_pass++;
    n_checks++; if (bus.o_round !== 8'd0) $display("FAIL midreset_round: got %0d want 0", bus.o_round); else n_pass++;
    n_checks++; if (bus.o_score !== 8'd0) $display("FAIL midreset_score: got %0d want 0", bus.o_score); else n_pass++;
    bus.i_start = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    repeat (2) tick();
    n_checks++; if (bus.o_target_valid !== 1'b0) $display("FAIL postreset_idle: valid got %0b want 0", bus.o_target_valid); else n_pass++;
    exp_q.delete();
    m_round = 0;
    bus.i_rand = 4'd4;
    model_spawn(4'd4);
    bus.i_start = 1'b1;
    repeat (2) tick();
    n_checks++; if (bus.o_target_valid !== 1'b1) $display("FAIL restart_valid: got %0b want 1", bus.o_target_valid); else n_pass++;
    e = pop_exp();
    n_checks++; if (bus.o_cell !== e) $display("FAIL restart_cell: got %0d want %0d", bus.o_cell, e); else n_pass++;
  endtask

  // Entered with the first target of a game just seen high.
  task automatic test_active_edge_ignored();
    int len;
    bit ok;
    len = 1;
    for (int k = 0; k < 50 && bus.o_target_valid; k++) begin
      if (len == 2) bus.i_start = 1'b0;
      if (len == 3) bus.i_start = 1'b1;
      tick();
      if (bus.o_target_valid) len++;
    end
    n_checks++; if (len !== LT) $display("FAIL active_edge_len: got %0d want %0d", len, LT); else n_pass++;
    n_checks++; if (bus.o_miss !== 8'd1) $display("FAIL active_edge_miss: got %0d want 1", bus.o_miss); else n_pass++;
    wait_done(ok);
    n_checks++; if (bus.o_round !== 8'd3) $display("FAIL active_edge_round: got %0d want 3", bus.o_round); else n_pass++;
  endtask

  task automatic test_restart_from_done();
    logic [3:0] e;
    bus.i_start = 1'b0;
    tick();
    exp_q.delete();
    m_round = 0;
    bus.i_rand = 4'd9;
    model_spawn(4'd9);
    bus.i_start = 1'b1;
    tick();
    n_checks++; if (bus.o_done !== 1'b0) $display("FAIL restart_done: got %0b want 0", bus.o_done); else n_pass++;
    n_checks++; if (bus.o_miss !== 8'd0) $display("FAIL restart_miss: got %0d want 0", bus.o_miss); else n_pass++;
    n_checks++; if (bus.o_round !== 8'd0) $display("FAIL restart_round: got %0d want 0", bus.o_round); else n_pass++;
    n_checks++; if (bus.o_target_valid !== 1'b0) $display("FAIL restart_early_valid: got %0b want 0", bus.o_target_valid); else n_pass++;
    tick();
    n_checks++; if (bus.o_target_valid !== 1'b1) $display("FAIL restart_new_valid: got %0b want 1", bus.o_target_valid); else n_pass++;
    e = pop_exp();
    n_checks++; if (bus.o_cell !== e) $display("FAIL restart_new_cell: got %0d want %0d", bus.o_cell, e); else n_pass++;
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_rand  = 4'd0;
    bus.i_hit   = 1'b0;
    i_rst_n     = 1'b0;
    repeat (2) tick();
    test_reset();
    test_first_spawn();
    test_no_hits();
    test_hits();
    test_wrap();
    test_hit_timeout_and_reset();
    test_active_edge_ignored();
    test_restart_from_done();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a wait loop is ever broken.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

endmodule
